digit_serial_adder: RTL and testbench

Parametrised multi-cycle successor to the 4-bit ripple adder. It adds or subtracts two WIDTH-bit operands DIGIT bits per clock, reusing one DIGIT-bit ripple slice over WIDTH/DIGIT cycles. Operands enter and results leave through valid/ready handshakes. It produces Sum, Cout and signed Overflow, and sits between operand sources and any consumer that tolerates multi-cycle latency.

---
 rtl/digit_serial_adder_pkg.sv | 26 ++
 rtl/digit_serial_adder_if.sv | 36 +++
 rtl/digit_serial_adder_digit_adder.sv | 57 +++++
 rtl/digit_serial_adder.sv | 145 ++++++++++++++
 tb/tb_digit_serial_adder.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/digit_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the digit-serial adder:
//     state_e        - controller states (IDLE, BUSY, DONE)
//     params_legal() - true when a WIDTH/DIGIT pair can be built
//     digit_count()  - number of DIGIT-bit passes needed for WIDTH bits
// -----------------------------------------------------------------------------
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic bit params_legal(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && (width % digit == 0);
  endfunction

  // Returns 1 for an illegal pair so the surrounding elaboration stays sane;
  // the top level raises the actual elaboration error.
  function automatic int digit_count(input int width, input int digit);
    return params_legal(width, digit) ? width / digit : 1;
  endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// -----------------------------------------------------------------------------
// digit_serial_adder_if
//   Operand and result handshakes of the digit-serial adder.
//     in_valid/in_ready   - operand set handshake (A, B, Cin, Sub)
//     out_valid/out_ready - result handshake (Sum, Cout, Overflow)
//   Modports:
//     master - operand producer / result consumer
//     slave  - the adder itself
// -----------------------------------------------------------------------------
interface digit_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Overflow;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, Overflow
  );

  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, Sum, Cout, Overflow
  );

endinterface

// File: rtl/digit_serial_adder_digit_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   One-bit full adder cell.
//     a_i, b_i, cin_i -> sum_o, cout_o
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// -----------------------------------------------------------------------------
// digit_adder
//   Combinational DIGIT-bit ripple-carry slice built from full_adder cells.
//     a_i, b_i   - DIGIT-bit operand digits
//     cin_i      - carry into bit 0
//     sum_o      - DIGIT-bit sum
//     cout_o     - carry out of the top bit
//     c_msb_in_o - carry into the top bit (equals cin_i when DIGIT == 1)
// -----------------------------------------------------------------------------
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             cout_o,
  output logic             c_msb_in_o
);

  // carry[i] is the carry into bit i; carry[DIGIT] leaves the slice.
  logic [DIGIT:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < DIGIT; i++) begin : g_ripple
    full_adder u_fa (
      .a_i    (a_i[i]),
      .b_i    (b_i[i]),
      .cin_i  (carry[i]),
      .sum_o  (sum_o[i]),
      .cout_o (carry[i+1])
    );
  end

  assign cout_o     = carry[DIGIT];
  assign c_msb_in_o = carry[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// -----------------------------------------------------------------------------
// digit_serial_adder
//   Adds (Sub=0: A+B+Cin) or subtracts (Sub=1: A+~B+!Cin) two WIDTH-bit
//   operands, DIGIT bits per clock, reusing one digit_adder slice for
//   N = WIDTH/DIGIT cycles. Result appears N cycles after operand acceptance
//   and is held until the consumer takes it.
//     clk - rising-edge clock
//     rst - synchronous active-high reset
//     bus - digit_serial_adder_if.slave (operand and result handshakes)
// -----------------------------------------------------------------------------
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  digit_serial_adder_if.slave  bus
);

  if (!params_legal(WIDTH, DIGIT)) begin : g_param_check
    $error("digit_serial_adder: WIDTH=%0d DIGIT=%0d is not a legal pair", WIDTH, DIGIT);
  end

  localparam int N     = digit_count(WIDTH, DIGIT);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [DIGIT-1:0]   slice_sum;
  logic               slice_cout;
  logic               slice_c_msb;
  logic               last_digit;

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_slice (
    .a_i        (a_sh_q[DIGIT-1:0]),
    .b_i        (b_sh_q[DIGIT-1:0]),
    .cin_i      (carry_q),
    .sum_o      (slice_sum),
    .cout_o     (slice_cout),
    .c_msb_in_o (slice_c_msb)
  );

  assign last_digit = (cnt_q == CNT_W'(N - 1));

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    a_sh_d        = a_sh_q;
    b_sh_d        = b_sh_q;
    sum_d         = sum_q;
    carry_d       = carry_q;
    cout_d        = cout_q;
    ovf_d         = ovf_q;
    cnt_d         = cnt_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          a_sh_d  = bus.A;
          // Subtraction is A + ~B + 1 with the sense of Cin folded in.
          b_sh_d  = bus.Sub ? ~bus.B : bus.B;
          carry_d = bus.Cin ^ bus.Sub;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        // Each new digit enters at the top; after N passes the first digit
        // computed has walked down to Sum[DIGIT-1:0].
        sum_d   = WIDTH'({slice_sum, sum_q} >> DIGIT);
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_digit) begin
          cout_d  = slice_cout;
          ovf_d   = slice_cout ^ slice_c_msb;
          state_d = DONE;
        end
      end

      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Never advertise readiness while reset is applied.
    if (rst) begin
      bus.in_ready = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the operand shift registers are left out of reset; they are always
  // loaded on acceptance before being read, so resetting them buys nothing.
  always_ff @(posedge clk) begin
    a_sh_q <= a_sh_d;
    b_sh_q <= b_sh_d;
  end

  assign bus.Sum      = sum_q;
  assign bus.Cout     = cout_q;
  assign bus.Overflow = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_digit_serial_adder
//   Four adder instances: (WIDTH,DIGIT) = (4,4), (8,1), (16,4), (32,8).
//   Directed cases run on the (16,4) instance, then all four run randomized
//   operations in parallel against an arithmetic reference model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_digit_serial_adder;

  localparam int NCFG = 4;
  localparam int WID [NCFG] = '{4, 8, 16, 32};
  localparam int DIG [NCFG] = '{4, 1, 4, 8};
  localparam int NOPS = 1000;

  logic clk;
  logic rst;

  logic        in_valid_v  [NCFG];
  logic        out_ready_v [NCFG];
  logic        cin_v       [NCFG];
  logic        sub_v       [NCFG];
  logic [31:0] a_v         [NCFG];
  logic [31:0] b_v         [NCFG];

  logic        in_ready_w  [NCFG];
  logic        out_valid_w [NCFG];
  logic        cout_w      [NCFG];
  logic        ovf_w       [NCFG];
  logic [31:0] sum_w       [NCFG];

  int n_cmp = 0;
  int n_err = 0;

  digit_serial_adder_if #(.WIDTH(4))  if0 ();
  digit_serial_adder_if #(.WIDTH(8))  if1 ();
  digit_serial_adder_if #(.WIDTH(16)) if2 ();
  digit_serial_adder_if #(.WIDTH(32)) if3 ();

`define TB_HOOK(IDX, IFN, W) \
  assign IFN.in_valid    = in_valid_v[IDX]; \
  assign IFN.out_ready   = out_ready_v[IDX]; \
  assign IFN.Cin         = cin_v[IDX]; \
  assign IFN.Sub         = sub_v[IDX]; \
  assign IFN.A           = a_v[IDX][W-1:0]; \
  assign IFN.B           = b_v[IDX][W-1:0]; \
  assign in_ready_w[IDX]  = IFN.in_ready; \
  assign out_valid_w[IDX] = IFN.out_valid; \
  assign cout_w[IDX]      = IFN.Cout; \
  assign ovf_w[IDX]       = IFN.Overflow; \
  assign sum_w[IDX]       = 32'(IFN.Sum);

  `TB_HOOK(0, if0, 4)
  `TB_HOOK(1, if1, 8)
  `TB_HOOK(2, if2, 16)
  `TB_HOOK(3, if3, 32)

`undef TB_HOOK

  digit_serial_adder #(.WIDTH(4),  .DIGIT(4)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  digit_serial_adder #(.WIDTH(8),  .DIGIT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  digit_serial_adder #(.WIDTH(32), .DIGIT(8)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on WIDTH-bit values.
  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub,
                       output logic [31:0] s, output logic co, output logic ov);
    logic [63:0] mask;
    logic [63:0] av;
    logic [63:0] bv;
    logic [63:0] t;
    mask = (64'd1 << w) - 64'd1;
    av   = {32'd0, a} & mask;
    bv   = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
    t    = av + bv + 64'(cin ^ sub);
    s    = t[31:0] & mask[31:0];
    co   = t[w];
    ov   = (av[w-1] == bv[w-1]) && (t[w-1] != av[w-1]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on instance k. hold = cycles of out_ready=0
  // after out_valid; noisy = toggle in_valid with junk operands while busy.
  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input int hold, input bit noisy);
    logic [31:0] es;
    logic        ec;
    logic        eo;
    int          waited;
    int          lat;
    model(WID[k], a, b, cin, sub, es, ec, eo);

    a_v[k] = a; b_v[k] = b; cin_v[k] = cin; sub_v[k] = sub;
    in_valid_v[k] = 1'b1;
    waited = 0;
    while (!in_ready_w[k] && waited < 50) begin
      tick();
      waited++;
    end
    check($sformatf("c%0d_in_ready_before_accept", k), 64'(in_ready_w[k]), 64'd1);
    tick();  // acceptance edge

    // Operands change after acceptance; the result must not follow them.
    in_valid_v[k] = 1'b0;
    a_v[k] = $urandom; b_v[k] = $urandom;
    cin_v[k] = 1'($urandom); sub_v[k] = 1'($urandom);

    lat = 0;
    while (!out_valid_w[k] && lat < 200) begin
      if (noisy) begin
        check($sformatf("c%0d_in_ready_busy", k), 64'(in_ready_w[k]), 64'd0);
        in_valid_v[k] = 1'($urandom);
        a_v[k] = $urandom; b_v[k] = $urandom;
      end
      tick();
      lat++;
    end
    in_valid_v[k] = 1'b0;
    check($sformatf("c%0d_latency", k), 64'(lat), 64'(WID[k] / DIG[k]));
    check($sformatf("c%0d_sum", k), 64'(sum_w[k]), 64'(es));
    check($sformatf("c%0d_cout", k), 64'(cout_w[k]), 64'(ec));
    check($sformatf("c%0d_ovf", k), 64'(ovf_w[k]), 64'(eo));

    for (int i = 0; i < hold; i++) begin
      tick();
      check($sformatf("c%0d_hold_valid", k), 64'(out_valid_w[k]), 64'd1);
      check($sformatf("c%0d_hold_in_ready", k), 64'(in_ready_w[k]), 64'd0);
      check($sformatf("c%0d_hold_sum", k), 64'(sum_w[k]), 64'(es));
      check($sformatf("c%0d_hold_flags", k), {62'd0, cout_w[k], ovf_w[k]}, {62'd0, ec, eo});
    end

    out_ready_v[k] = 1'b1;
    tick();
    out_ready_v[k] = 1'b0;
    check($sformatf("c%0d_valid_after_take", k), 64'(out_valid_w[k]), 64'd0);
    check($sformatf("c%0d_ready_after_take", k), 64'(in_ready_w[k]), 64'd1);
  endtask

  task automatic sweep(input int k);
    for (int i = 0; i < NOPS; i++) begin
      run_op(k, $urandom, $urandom, 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    bit seen_valid;
    for (int k = 0; k < NCFG; k++) begin
      in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b0;
      cin_v[k] = 1'b0; sub_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0;
    end

    // Reset: in_ready stays low while rst is high, then IDLE with cleared outputs.
    rst = 1'b1;
    tick();
    check("rst_in_ready_low", 64'(in_ready_w[2]), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready_w[2]), 64'd1);
    check("rst_out_valid", 64'(out_valid_w[2]), 64'd0);
    check("rst_sum", 64'(sum_w[2]), 64'd0);
    check("rst_flags", {62'd0, cout_w[2], ovf_w[2]}, 64'd0);

    // Directed boundary cases on the 16-bit / 4-bit-digit instance.
    run_op(2, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 0, 1'b0);
    run_op(2, 32'h0000, 32'h0001, 1'b0, 1'b1, 0, 1'b0);
    run_op(2, 32'h8000, 32'h0001, 1'b0, 1'b1, 0, 1'b0);
    run_op(2, 32'hFFFF, 32'h0001, 1'b1, 1'b0, 5, 1'b0);

    // Reset while cnt==2 abandons the operation.
    a_v[2] = 32'h1234; b_v[2] = 32'h1111; cin_v[2] = 1'b0; sub_v[2] = 1'b0;
    in_valid_v[2] = 1'b1;
    check("mid_rst_ready_before", 64'(in_ready_w[2]), 64'd1);
    tick();           // accepted, cnt=0
    in_valid_v[2] = 1'b0;
    tick();           // cnt=1
    tick();           // cnt=2
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready_low", 64'(in_ready_w[2]), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_idle_ready", 64'(in_ready_w[2]), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid_w[2]), 64'd0);
    check("mid_rst_sum", 64'(sum_w[2]), 64'd0);
    check("mid_rst_flags", {62'd0, cout_w[2], ovf_w[2]}, 64'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid_w[2]) seen_valid = 1'b1;
    end
    check("mid_rst_no_result", 64'(seen_valid), 64'd0);
    run_op(2, 32'h1234, 32'h0FF0, 1'b1, 1'b1, 1, 1'b0);

    // in_valid toggling with new operands while busy is ignored.
    run_op(2, 32'hA5A5, 32'h5A5B, 1'b0, 1'b0, 2, 1'b1);
    run_op(2, 32'h0001, 32'h0002, 1'b0, 1'b1, 0, 1'b1);

    // Randomized sweep of all four configurations in parallel.
    fork
      sweep(0);
      sweep(1);
      sweep(2);
      sweep(3);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
